apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Shares a single APB4 master port among `NUM_REQ` on-chip requesters using a simple valid/ready request channel and round-robin arbitration. Sequences the APB setup and access phases and returns read data and error per transaction. Aborts a stalled transfer with a timeout error. Sits between processor/DMA-side register requesters and the APB Master modport feeding the peripheral decoder.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `ADDR_WIDTH`, default 32: APB address width.
- `DATA_WIDTH`, default 32: APB data width.
- `TIMEOUT_CYCLES`, default 256: maximum number of ACCESS cycles without `pready`. 0 disables the timeout.
- `clk_i`  in  1  single clock; also forwarded as `pclk_o`.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NUM_REQ  per-requester request valid.
- `req_ready_o`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_addr_i`  in  NUM_REQ×ADDR_WIDTH  request address.
- `req_write_i`  in  NUM_REQ  1 = write, 0 = read.
- `req_wdata_i`  in  NUM_REQ×DATA_WIDTH  write data.
- `rsp_valid_o`  out  NUM_REQ  one-cycle response pulse to the owning requester.
- `rsp_rdata_o`  out  DATA_WIDTH  shared read data; valid with `rsp_valid_o`.
- `rsp_err_o`  out  1  shared error flag: `pslverr` or timeout.
- `pclk_o`  out  1  equal to `clk_i`.
- `paddr_o`  out  ADDR_WIDTH  APB address.
- `psel_o`  out  1  APB select.
- `penable_o`  out  1  APB enable.
- `pwrite_o`  out  1  APB direction.
- `pwdata_o`  out  DATA_WIDTH  APB write data.
- `pready_i`  in  1  APB ready.
- `prdata_i`  in  DATA_WIDTH  APB read data.
- `pslverr_i`  in  1  APB slave error.

## Operation
FSM states are IDLE, SETUP and ACCESS.

- **IDLE**
  - `req_ready_o` is one-hot to the round-robin winner among asserted `req_valid_i`. It is combinational from `req_valid_i` and the pointer.
  - On handshake: capture addr, write, wdata and owner index; go to SETUP.
  - If no request is valid, stay in IDLE.
- **SETUP**
  - `psel_o`=1, `penable_o`=0, with the captured addr, write and wdata driven.
  - Always go to ACCESS next cycle.
- **ACCESS**
  - `psel_o`=1, `penable_o`=1.
  - If `pready_i`=1: register `prdata_i` (reads only; writes return 0) and `pslverr_i`; pulse `rsp_valid_o[owner]` next cycle; go to IDLE.
  - Otherwise increment the timeout counter. When the counter reaches `TIMEOUT_CYCLES`: go to IDLE, respond with `rsp_err_o`=1 and `rsp_rdata_o`=0.
- **Round-robin**
  - Pointer resets to 0. Search order is pointer, pointer+1, … mod `NUM_REQ`.
  - After a grant to index i, pointer ← (i+1) mod `NUM_REQ`.
  - The pointer updates only on handshake.
- **Request hold:** a requester holds valid and its fields stable until ready. Deasserting valid before ready is allowed (request withdrawn). Fields are ignored after acceptance.
- **APB stability:** APB outputs stay stable from SETUP through the last ACCESS cycle. `paddr_o`, `pwrite_o` and `pwdata_o` hold their last values in IDLE.
- **Reset values:** state IDLE; `psel_o`, `penable_o`, `rsp_valid_o`, `req_ready_o` all 0; `paddr_o`, `pwdata_o`, `rsp_rdata_o` all 0; `pwrite_o`=0; `rsp_err_o`=0; pointer 0; counter 0.
- **Reset mid-transfer:** `psel_o` and `penable_o` drop in the cycle after `rst_i` is sampled. No response is issued.

## Timing
- **Best-case latency:** handshake in cycle 0, SETUP in cycle 1, ACCESS in cycle 2 with `pready` high, `rsp_valid_o` in cycle 3.
- **Back-to-back:** a new handshake is possible in cycle 3. Sustained throughput is one transfer per 3 cycles.
- **Wait states:** each cycle of `pready_i`=0 adds one cycle to latency.
- **Timeout:** the counter counts ACCESS cycles with `pready` low. Width is $clog2(TIMEOUT_CYCLES+1). It clears on entry to SETUP.
  - `TIMEOUT_CYCLES`=N: the Nth consecutive low ACCESS cycle triggers the abort.
  - The error response appears the following cycle, and `psel_o` is 0 in that same cycle.
- **Simultaneous `pready` and timeout:** `pready` wins; a normal response is returned.
- **Response registers:** `rsp_rdata_o` and `rsp_err_o` are registered and hold until the next response.

## Structure
- Package `apb_arb_pkg` holds:
  - the state enum `apb_arb_state_e` (IDLE, SETUP, ACCESS);
  - the width helper for the timeout counter.
- Sub-module `rr_arbiter_onehot` (parameter `NUM_REQ`) contains the pointer register.
  - Inputs: `req`, `advance`.
  - Outputs: one-hot `gnt` and binary `idx`.
- All other logic is in `apb_master_arbiter`.

## Test plan
- Single read: req0 addr 0x10, slave `pready`=1 and prdata 0xDEADBEEF in the first ACCESS cycle → `psel` high cycles 1–2, `penable` high cycle 2, `rsp_valid_o`=0b0001 in cycle 3 with rdata 0xDEADBEEF and err 0.
- Round-robin: all 4 requesters valid continuously, zero-wait slave → grant order 0,1,2,3,0; one handshake every 3 cycles.
- Wait states and error: write to 0x20 with data 0x5A, `pready` low 3 cycles then high with `pslverr`=1 → APB signals stable for all 4 ACCESS cycles, then `rsp_err_o`=1 and rdata 0.
- Timeout: `TIMEOUT_CYCLES`=4 and `pready` held low → `psel` drops after the 4th ACCESS cycle, `rsp_valid` with err=1 and rdata 0, next request accepted in that same cycle.
- Reset during ACCESS: `rst_i` pulsed while stalled → next cycle all outputs at reset values, no `rsp_valid`, pointer 0.
- Withdrawn request: req2 valid for 1 cycle while busy, then dropped → never granted, no response on index 2.

Source files
------------

// File: rtl/apb_arb_pkg.sv
// Shared types for the APB master arbiter: FSM state encoding
// and the sizing helper for the ACCESS-phase timeout counter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_arb_state_e;

    // A zero timeout still needs a one-bit counter to keep widths legal.
    function automatic int tmo_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter: one-hot grant and binary index of the winner.
// Ports: clk_i, rst_i, req, advance (pointer moves past winner), gnt, idx.
module rr_arbiter_onehot #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req,
    input  logic                       advance,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] ptr;
    logic [IW:0]   pos;
    logic          found;

    // Search starts at the pointer and wraps modulo NUM_REQ.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, ptr} + (IW+1)'(k);
            if (pos >= (IW+1)'(NUM_REQ)) begin
                pos = pos - (IW+1)'(NUM_REQ);
            end
            if (!found && req[pos[IW-1:0]]) begin
                found             = 1'b1;
                gnt[pos[IW-1:0]]  = 1'b1;
                idx               = pos[IW-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB4 master port among NUM_REQ valid/ready requesters.
// Ports: clk_i/rst_i; req_* request channel; rsp_* response; p* APB master.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          pclk_o,
    output logic [ADDR_WIDTH-1:0]         paddr_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [DATA_WIDTH-1:0]         pwdata_o,
    input  logic                          pready_i,
    input  logic [DATA_WIDTH-1:0]         prdata_i,
    input  logic                          pslverr_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = tmo_cnt_width(TIMEOUT_CYCLES);

    apb_arb_state_e state, state_nxt;

    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic [IW-1:0]      owner;
    logic [CW-1:0]      cnt;
    logic               handshake;
    logic               tmo_hit;
    logic [NUM_REQ-1:0] owner_onehot;

    rr_arbiter_onehot #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req_valid_i),
        .advance (handshake),
        .gnt     (gnt),
        .idx     (win_idx)
    );

    assign pclk_o       = clk_i;
    assign psel_o       = (state != IDLE);
    assign penable_o    = (state == ACCESS);
    assign req_ready_o  = (state == IDLE && !rst_i) ? gnt : '0;
    assign handshake    = (state == IDLE) && !rst_i && (|gnt);
    assign owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;

    // Abort on the Nth consecutive low ACCESS cycle; pready has priority.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && !pready_i &&
                     (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (handshake) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_i || tmo_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            paddr_o     <= '0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            owner       <= '0;
            cnt         <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            rsp_valid_o <= '0;
            if (handshake) begin
                paddr_o  <= req_addr_i[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                pwrite_o <= req_write_i[win_idx];
                pwdata_o <= req_wdata_i[win_idx*DATA_WIDTH +: DATA_WIDTH];
                owner    <= win_idx;
                cnt      <= '0;
            end
            if (state == ACCESS) begin
                if (pready_i) begin
                    rsp_valid_o <= owner_onehot;
                    rsp_rdata_o <= pwrite_o ? '0 : prdata_i;
                    rsp_err_o   <= pslverr_i;
                end else begin
                    cnt <= cnt + 1'b1;
                    if (tmo_hit) begin
                        rsp_valid_o <= owner_onehot;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Randomized scoreboard bench for apb_master_arbiter.
// Transaction-level model: round-robin order, response contents, latency.
module tb_apb_master_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_write;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            pclk;
    logic [AW-1:0]   paddr;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            pready;
    logic [DW-1:0]   prdata;
    logic            pslverr;

    apb_master_arbiter #(
        .NUM_REQ        (N),
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .req_write_i (req_write),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .pclk_o      (pclk),
        .paddr_o     (paddr),
        .psel_o      (psel),
        .penable_o   (penable),
        .pwrite_o    (pwrite),
        .pwdata_o    (pwdata),
        .pready_i    (pready),
        .prdata_i    (prdata),
        .pslverr_i   (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            owner;
        logic [AW-1:0] addr;
        logic          wr;
        logic [DW-1:0] wdata;
        int            hs_cyc;
    } req_t;

    typedef struct {
        int            owner;
        logic [DW-1:0] rdata;
        logic          err;
        int            lat;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    int ptr_m       = 0;
    bit busy_m      = 1'b0;
    int busy_since  = 0;
    bit mon_en      = 1'b0;
    bit stall_mode  = 1'b0;
    bit hs_seen[N];
    int first_hs    = -1;

    int            w_s;
    int            acc_s;
    logic [DW-1:0] rd_s;
    logic          err_s;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Winner = first asserted valid scanning upward from the pointer.
    function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v,
                                               input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return N'(1) << ((p + k) % N);
        end
        return '0;
    endfunction

    always @(posedge clk) cyc++;

    // Monitor: responses, ready one-hot, handshakes.
    always @(negedge clk) begin : monitor
        rsp_t          e;
        req_t          r;
        logic [N-1:0]  hs;
        if (mon_en) begin
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0 || req_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got %b expected none",
                             rsp_valid);
                end else begin
                    e = rsp_q.pop_front();
                    r = req_q.pop_front();
                    check("rsp_owner", 64'(rsp_valid), 64'(1) << e.owner);
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_latency", 64'(cyc - r.hs_cyc), 64'(e.lat));
                end
                busy_m = 1'b0;
            end else if (busy_m && (cyc - busy_since) > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL rsp_timeout: got none expected response");
                busy_m = 1'b0;
                req_q.delete();
                rsp_q.delete();
            end
            check("req_ready", 64'(req_ready),
                  busy_m ? 64'(0) : 64'(rr_expect(req_valid, ptr_m)));
            hs = req_valid & req_ready;
            for (int i = 0; i < N; i++) begin
                if (hs[i]) begin
                    r.owner  = i;
                    r.addr   = req_addr[i*AW +: AW];
                    r.wr     = req_write[i];
                    r.wdata  = req_wdata[i*DW +: DW];
                    r.hs_cyc = cyc;
                    req_q.push_back(r);
                    ptr_m      = (i + 1) % N;
                    busy_m     = 1'b1;
                    busy_since = cyc;
                    hs_seen[i] = 1'b1;
                    if (first_hs < 0) first_hs = i;
                end
            end
        end
    end

    // APB slave: random wait states, data and error; predicts response.
    always @(posedge clk) begin : slave
        rsp_t e;
        #1;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
        if (psel && req_q.size() != 0) begin
            check("paddr", 64'(paddr), 64'(req_q[0].addr));
            check("pwrite", 64'(pwrite), 64'(req_q[0].wr));
            check("pwdata", 64'(pwdata), 64'(req_q[0].wdata));
        end else if (psel && mon_en) begin
            n_tests++;
            n_fail++;
            $display("FAIL apb_no_req: got psel=1 expected 0");
        end
        if (psel && !penable && req_q.size() != 0) begin
            w_s   = stall_mode ? 1000 : int'($urandom_range(0, 6));
            acc_s = 0;
            rd_s  = $urandom;
            err_s = 1'($urandom_range(0, 1));
            e.owner = req_q[0].owner;
            if (w_s >= TMO) begin
                e.rdata = '0;
                e.err   = 1'b1;
                e.lat   = TMO + 2;
            end else begin
                e.rdata = req_q[0].wr ? '0 : rd_s;
                e.err   = err_s;
                e.lat   = w_s + 3;
            end
            rsp_q.push_back(e);
        end else if (psel && penable) begin
            if (acc_s == w_s) begin
                pready  = 1'b1;
                prdata  = rd_s;
                pslverr = err_s;
            end
            acc_s++;
        end
    end

    task automatic new_req(input int i);
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = $urandom;
        req_write[i]          = 1'($urandom_range(0, 1));
        req_wdata[i*DW +: DW] = $urandom;
    endtask

    task automatic drive_random(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req_valid[i]) begin
                    if (hs_seen[i]) begin
                        req_valid[i] = 1'b0;
                        hs_seen[i]   = 1'b0;
                    end else if ($urandom_range(0, 15) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    new_req(i);
                end
            end
        end
    endtask

    task automatic drain();
        int t;
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int i = 0; i < N; i++) hs_seen[i] = 1'b0;
        t = 0;
        while ((busy_m || rsp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_idle", 64'(busy_m), 64'(0));
    endtask

    initial begin
        int t;
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        pslverr   = 1'b0;
        for (int i = 0; i < N; i++) hs_seen[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_psel", 64'(psel), 64'(0));
        check("rst_penable", 64'(penable), 64'(0));
        check("rst_paddr", 64'(paddr), 64'(0));
        check("rst_pwdata", 64'(pwdata), 64'(0));
        check("rst_pwrite", 64'(pwrite), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("rst_rsp_err", 64'(rsp_err), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(0));

        mon_en = 1'b1;
        drive_random(1500);
        drain();

        // Reset while the slave stalls in ACCESS.
        @(posedge clk);
        #1;
        stall_mode = 1'b1;
        new_req(1);
        t = 0;
        while (!hs_seen[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_hs", 64'(hs_seen[1]), 64'(1));
        @(posedge clk);
        #1;
        req_valid  = '0;
        hs_seen[1] = 1'b0;
        t = 0;
        while (!(psel && penable) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("stall_access", 64'(psel && penable), 64'(1));
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_psel", 64'(psel), 64'(0));
        check("midrst_penable", 64'(penable), 64'(0));
        check("midrst_paddr", 64'(paddr), 64'(0));
        check("midrst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        check("midrst_rsp_err", 64'(rsp_err), 64'(0));
        for (int k = 0; k < 4; k++) begin
            check("midrst_no_rsp", 64'(rsp_valid), 64'(0));
            @(negedge clk);
        end
        req_q.delete();
        rsp_q.delete();
        ptr_m      = 0;
        busy_m     = 1'b0;
        stall_mode = 1'b0;
        first_hs   = -1;
        for (int i = 0; i < N; i++) hs_seen[i] = 1'b0;

        // Pointer must restart at requester 0.
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) new_req(i);
        mon_en = 1'b1;
        t = 0;
        while (first_hs < 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ptr_after_rst", 64'(first_hs), 64'(0));
        drive_random(300);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
